bool_arbiter: RTL and testbench

Round-robin arbiter and result register that shares a single 32-bit BOOL function unit among N requesters. Each requester presents a BFN/A/B operation with a valid/ready handshake. The block grants one requester per cycle, evaluates Y = BFN[{B,A}] bitwise, and returns the result with the requester ID through a single-entry output register with valid/ready. It sits between the BETA execute-stage issue ports and the shared logic unit.

---
 rtl/bool_arb_pkg.sv | 18 +
 rtl/bool_arbiter_if.sv | 28 ++
 rtl/bool_arbiter_rr_pick.sv | 35 +++
 rtl/bool_arbiter.sv | 103 ++++++++++
 tb/tb_bool_arbiter.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/bool_arb_pkg.sv
// Shared constants for the BOOL-unit arbiter: default sizing and the common BFN truth-table codes.
// A BFN code is a 4-entry truth table indexed by {b,a}.
package bool_arb_pkg;

  localparam int N_DEF = 4;
  localparam int W_DEF = 32;

  typedef enum logic [3:0] {
    BFN_ZERO = 4'b0000,
    BFN_XOR  = 4'b0110,
    BFN_AND  = 4'b1000,
    BFN_A    = 4'b1010,
    BFN_B    = 4'b1100,
    BFN_OR   = 4'b1110,
    BFN_ONE  = 4'b1111
  } bfn_e;

endpackage

// File: rtl/bool_arbiter_if.sv
// Request/response bundle between N issue ports and the shared BOOL unit.
// master = issue-port/consumer side, slave = arbiter side.
interface bool_arbiter_if #(
  parameter int N = 4,
  parameter int W = 32
);
  localparam int IDW = $clog2(N);

  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [4*N-1:0] req_bfn;
  logic [W*N-1:0] req_a;
  logic [W*N-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0]   rsp_y;

  modport master (
    output req_valid, req_bfn, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_y
  );

  modport slave (
    input  req_valid, req_bfn, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_y
  );
endinterface

// File: rtl/bool_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first set bit of valid searching start, start+1, ..., wrapping.
// Zero latency; grant is all-zero when no bit is set.
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   valid,
  input  logic [IDW-1:0] start,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] idx
);

  always_comb begin
    logic           found;
    logic [IDW:0]   pos;
    logic [IDW-1:0] j;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    j     = '0;
    for (int off = 0; off < N; off++) begin
      // modular add without a divider; start < N so one subtraction suffices
      pos = {1'b0, start} + (IDW+1)'(off);
      if (pos >= (IDW+1)'(N)) pos = pos - (IDW+1)'(N);
      j = pos[IDW-1:0];
      if (!found && valid[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end

endmodule

// File: rtl/bool_arbiter.sv
// Round-robin share of one W-bit BOOL unit (Y[k] = BFN[{B[k],A[k]}]) among N requesters; result one cycle after grant.
// Grants only when the result register is empty or draining; BOOL_ARB_FIXED_PRIO_EN selects lowest-index-wins priority.
module bool_unit #(
  parameter int W = 32
) (
  input  logic [3:0]   bfn,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  always_comb begin
    y = '0;
    for (int k = 0; k < W; k++) y[k] = bfn[{b[k], a[k]}];
  end
endmodule

module bool_arbiter
  import bool_arb_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           reset,
  bool_arbiter_if.slave  bus
);
  localparam int IDW = $clog2(N);

  logic           rsp_valid_q;
  logic [IDW-1:0] rsp_id_q;
  logic [W-1:0]   rsp_y_q;
  logic           can_accept;
  logic [IDW-1:0] start;
  logic [N-1:0]   pick_grant;
  logic [IDW-1:0] pick_idx;
  logic           xfer;
  logic [3:0]     bfn_arr [N];
  logic [W-1:0]   a_arr   [N];
  logic [W-1:0]   b_arr   [N];
  logic [W-1:0]   unit_y;

  assign can_accept = !rsp_valid_q || bus.rsp_ready;

`ifdef BOOL_ARB_FIXED_PRIO_EN
  assign start = '0;
`else
  logic [IDW-1:0] ptr;
  assign start = ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (xfer) begin
      ptr <= (pick_idx == IDW'(N-1)) ? '0 : pick_idx + IDW'(1);
    end
  end
`endif

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .valid (bus.req_valid & {N{can_accept && !reset}}),
    .start (start),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  assign bus.req_ready = pick_grant;
  assign xfer          = |pick_grant;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      bfn_arr[i] = bus.req_bfn[i*4 +: 4];
      a_arr[i]   = bus.req_a[i*W +: W];
      b_arr[i]   = bus.req_b[i*W +: W];
    end
  end

  bool_unit #(.W(W)) u_unit (
    .bfn (bfn_arr[pick_idx]),
    .a   (a_arr[pick_idx]),
    .b   (b_arr[pick_idx]),
    .y   (unit_y)
  );

  // a transfer overrides a same-cycle drain, so valid stays high
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_y_q     <= '0;
    end else if (xfer) begin
      rsp_valid_q <= 1'b1;
      rsp_id_q    <= pick_idx;
      rsp_y_q     <= unit_y;
    end else if (bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_y     = rsp_y_q;

endmodule

// File: tb/tb_bool_arbiter.sv
// Directed bench for bool_arbiter: reset, single op, fairness, backpressure, reset mid-op, BFN sweep.
module tb_bool_arbiter;
  import bool_arb_pkg::*;

  localparam int N = 4;
  localparam int W = 32;
  localparam logic [31:0] OPA = 32'hFF00FF00;
  localparam logic [31:0] OPB = 32'hFFFF0000;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  bool_arbiter_if #(.N(N), .W(W)) bus ();

  bool_arbiter #(.N(N), .W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [3:0] f);
    bus.req_bfn[i*4 +: 4] = f;
    bus.req_a[i*W +: W]   = OPA;
    bus.req_b[i*W +: W]   = OPB;
  endtask

  // expected result of the fairness op mix (r0 AND, r1 OR, r2 XOR, r3 B) on OPA/OPB
  function automatic logic [31:0] mix_y(input int id);
    case (id)
      0:       mix_y = 32'hFF000000;
      1:       mix_y = 32'hFFFFFF00;
      2:       mix_y = 32'h00FFFF00;
      default: mix_y = 32'hFFFF0000;
    endcase
  endfunction

  task automatic test_reset();
    reset         = 1'b1;
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
    bus.req_bfn   = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    set_op(0, BFN_AND); set_op(1, BFN_OR); set_op(2, BFN_XOR); set_op(3, BFN_B);
    for (int c = 0; c < 2; c++) begin
      step();
      total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b exp=0000", bus.req_ready); end
      total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.rsp_valid); end
      total++; if (bus.rsp_y !== 32'h0) begin bad++; $display("FAIL reset_y got=%h exp=00000000", bus.rsp_y); end
      total++; if (bus.rsp_id !== 2'd0) begin bad++; $display("FAIL reset_id got=%0d exp=0", bus.rsp_id); end
    end
    reset = 1'b0;
    #1;
    total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL reset_first_grant got=%b exp=0001", bus.req_ready); end
    step();
    bus.req_valid = '0;
    total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0) begin bad++; $display("FAIL reset_first_rsp valid=%b id=%0d exp valid=1 id=0", bus.rsp_valid, bus.rsp_id); end
    total++; if (bus.rsp_y !== 32'hFF000000) begin bad++; $display("FAIL reset_first_y got=%h exp=FF000000", bus.rsp_y); end
  endtask

  task automatic test_single();
    set_op(2, BFN_XOR);
    bus.req_valid = 4'b0100;
    #1;
    total++; if (bus.req_ready !== 4'b0100) begin bad++; $display("FAIL single_ready got=%b exp=0100", bus.req_ready); end
    step();
    bus.req_valid = '0;
    total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", bus.rsp_valid); end
    total++; if (bus.rsp_id !== 2'd2) begin bad++; $display("FAIL single_id got=%0d exp=2", bus.rsp_id); end
    total++; if (bus.rsp_y !== 32'h00FFFF00) begin bad++; $display("FAIL single_y got=%h exp=00FFFF00", bus.rsp_y); end
    step();
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL drain_valid got=%b exp=0", bus.rsp_valid); end
    total++; if (bus.rsp_y !== 32'h00FFFF00 || bus.rsp_id !== 2'd2) begin bad++; $display("FAIL drain_hold y=%h id=%0d exp y=00FFFF00 id=2", bus.rsp_y, bus.rsp_id); end
  endtask

  task automatic test_fairness();
    int exp_id;
    reset = 1'b1;
    step();
    reset = 1'b0;
    set_op(0, BFN_AND); set_op(1, BFN_OR); set_op(2, BFN_XOR); set_op(3, BFN_B);
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
`ifdef BOOL_ARB_FIXED_PRIO_EN
      exp_id = 0;
`else
      exp_id = c % 4;
`endif
      total++; if (bus.rsp_valid !== 1'b1 || int'(bus.rsp_id) != exp_id) begin bad++; $display("FAIL fair_id[%0d] valid=%b id=%0d exp id=%0d", c, bus.rsp_valid, bus.rsp_id, exp_id); end
      total++; if (bus.rsp_y !== mix_y(exp_id)) begin bad++; $display("FAIL fair_y[%0d] got=%h exp=%h", c, bus.rsp_y, mix_y(exp_id)); end
    end
    bus.req_valid = '0;
  endtask

  task automatic test_backpressure();
    int held_id, next_id;
    logic [3:0] next_rdy;
`ifdef BOOL_ARB_FIXED_PRIO_EN
    held_id = 0; next_id = 0; next_rdy = 4'b0001;
`else
    held_id = 1; next_id = 2; next_rdy = 4'b0100;
`endif
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      step();
      total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL bp_ready[%0d] got=%b exp=0000", c, bus.req_ready); end
      total++; if (bus.rsp_valid !== 1'b1 || int'(bus.rsp_id) != held_id || bus.rsp_y !== mix_y(held_id)) begin
        bad++; $display("FAIL bp_hold[%0d] valid=%b id=%0d y=%h exp id=%0d y=%h", c, bus.rsp_valid, bus.rsp_id, bus.rsp_y, held_id, mix_y(held_id));
      end
    end
    bus.rsp_ready = 1'b1;
    #1;
    total++; if (bus.req_ready !== next_rdy) begin bad++; $display("FAIL bp_release_ready got=%b exp=%b", bus.req_ready, next_rdy); end
    step();
    total++; if (bus.rsp_valid !== 1'b1 || int'(bus.rsp_id) != next_id || bus.rsp_y !== mix_y(next_id)) begin
      bad++; $display("FAIL bp_replace valid=%b id=%0d y=%h exp valid=1 id=%0d y=%h", bus.rsp_valid, bus.rsp_id, bus.rsp_y, next_id, mix_y(next_id));
    end
  endtask

  task automatic test_reset_midop();
    bus.rsp_ready = 1'b0;
    reset = 1'b1;
    #1;
    total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL midrst_ready got=%b exp=0000", bus.req_ready); end
    step();
    total++; if (bus.rsp_valid !== 1'b0 || bus.rsp_id !== 2'd0 || bus.rsp_y !== 32'h0) begin
      bad++; $display("FAIL midrst_state valid=%b id=%0d y=%h exp 0/0/00000000", bus.rsp_valid, bus.rsp_id, bus.rsp_y);
    end
    reset = 1'b0;
    bus.rsp_ready = 1'b1;
    #1;
    total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL midrst_grant got=%b exp=0001", bus.req_ready); end
    step();
    bus.req_valid = '0;
    total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0) begin bad++; $display("FAIL midrst_rsp valid=%b id=%0d exp valid=1 id=0", bus.rsp_valid, bus.rsp_id); end
    step();
  endtask

  task automatic test_function_sweep();
    logic [3:0]  f;
    logic [31:0] exp_y;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b0010;
    for (int c = 0; c < 16; c++) begin
      f = 4'(c);
      set_op(1, f);
      #1;
      total++; if (bus.req_ready !== 4'b0010) begin bad++; $display("FAIL sweep_ready[%0d] got=%b exp=0010", c, bus.req_ready); end
      step();
      // byte lanes of OPA/OPB hit {b,a} = 11,10,01,00 from MSB to LSB
      exp_y = {{8{f[3]}}, {8{f[2]}}, {8{f[1]}}, {8{f[0]}}};
      total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_y !== exp_y) begin
        bad++; $display("FAIL sweep_y[%b] valid=%b id=%0d y=%h exp y=%h id=1", f, bus.rsp_valid, bus.rsp_id, bus.rsp_y, exp_y);
      end
    end
    bus.req_valid = '0;
    step();
    total++; if (bus.rsp_valid !== 1'b0 || bus.rsp_y !== 32'hFFFFFFFF) begin bad++; $display("FAIL sweep_drain valid=%b y=%h exp valid=0 y=FFFFFFFF", bus.rsp_valid, bus.rsp_y); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_reset_midop();
    test_function_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
